muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit producing a HI/LO result pair.
- Successor to the fixed 32-bit divider: one engine serves MULT, MULTU, DIV and DIVU.
- The CPU control unit drives a start/done handshake; operands come from A/B, results go to HI/LO registers.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_if.sv | 24 ++
 rtl/muldiv_datapath.sv | 139 +++++++++++++
 rtl/muldiv_unit.sv | 105 ++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/done handshake, operands and HI/LO results between the control unit and muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = muldiv_pkg::MULDIV_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Shared shift-add / restoring-divide datapath with sign correction and HI/LO result registers.
// MULDIV_EARLY_TERM_EN adds the multiplier-zero detect and one-step final alignment.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_i,
  input  logic                   step_i,
  input  logic                   fix_i,
  input  logic [1:0]             op_i,
  input  logic [WIDTH-1:0]       a_i,
  input  logic [WIDTH-1:0]       b_i,
`ifdef MULDIV_EARLY_TERM_EN
  input  logic [$clog2(WIDTH):0] cnt_i,
  output logic                   early_o,
`endif
  output logic [WIDTH-1:0]       hi_o,
  output logic [WIDTH-1:0]       lo_o
);

  localparam int W2 = 2 * WIDTH;

  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   div_top, div_diff;
  logic             div_ge;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    sa    = op_is_signed(op_i) & a_i[WIDTH-1];
    sb    = op_is_signed(op_i) & b_i[WIDTH-1];
    a_mag = sa ? (~a_i + 1'b1) : a_i;
    b_mag = sb ? (~b_i + 1'b1) : b_i;

    // Multiply: low half holds the unprocessed multiplier bits, upper half the partial sum.
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: a borrow out of the trial subtraction means the divisor did not fit.
    div_top  = acc_q[W2-1:WIDTH-1];
    div_diff = div_top - {1'b0, m_q};
    div_ge   = ~div_diff[WIDTH];
    div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    prod_fix = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? (~acc_q[W2-1:WIDTH] + 1'b1) : acc_q[W2-1:WIDTH];
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask;
  logic             mul_zero;

  always_comb begin
    rem_mask = ~({WIDTH{1'b1}} << cnt_i);
    mul_zero = ((acc_q[WIDTH-1:0] & rem_mask) == '0);
    early_o  = ~is_div_q & mul_zero;
  end
`endif

  always_comb begin
    acc_d    = acc_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (load_i) begin
      is_div_d = op_is_div(op_i);
      neg_lo_d = sa ^ sb;
      if (op_is_div(op_i)) begin
        acc_d    = {{WIDTH{1'b0}}, a_mag};
        m_d      = b_mag;
        neg_hi_d = sa;
      end else begin
        acc_d    = {{WIDTH{1'b0}}, b_mag};
        m_d      = a_mag;
        neg_hi_d = sa ^ sb;
      end
    end else if (step_i) begin
      if (is_div_q) begin
        acc_d = div_next;
      end else begin
        acc_d = mul_next;
`ifdef MULDIV_EARLY_TERM_EN
        if (mul_zero) acc_d = acc_q >> cnt_i;
`endif
      end
    end else if (fix_i) begin
      if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[W2-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: FSM, iteration counter and start/done handshake.
// Build with MULDIV_EARLY_TERM_EN for variable-latency multiply early termination.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             load, step, fix;
  logic             early;

`ifndef MULDIV_EARLY_TERM_EN
  assign early = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          div_zero_d = 1'b0;
          // Divide by zero skips the datapath entirely so HI/LO keep the old result.
          if (op_is_div(bus.op) && (bus.b == '0)) begin
            div_zero_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            load    = 1'b1;
            cnt_d   = CNT_W'(WIDTH);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if ((cnt_q == CNT_W'(1)) || early) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  muldiv_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .step_i  (step),
    .fix_i   (fix),
    .op_i    (bus.op),
    .a_i     (bus.a),
    .b_i     (bus.b),
`ifdef MULDIV_EARLY_TERM_EN
    .cnt_i   (cnt_q),
    .early_o (early),
`endif
    .hi_o    (bus.hi),
    .lo_o    (bus.lo)
  );

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: table of ops with hand-computed HI/LO, plus corner sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  vec_t vecs[15];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done; optionally fires a stray start at cycle glitch_at.
  task automatic wait_done(input int glitch_at, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (c == glitch_at) begin
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic check_lat(input logic [1:0] op, input int lat, input int bcnt, input logic dz);
    int exp;
    exp = dz ? 1 : W + 2;
`ifdef MULDIV_EARLY_TERM_EN
    if (!dz && !op_is_div(op)) begin
      chk("mul_latency_in_range", 32'((lat >= 3) && (lat <= W + 2)), 32'd1);
      chk("busy_cycles", bcnt, lat);
    end else begin
      chk("latency", lat, exp);
      chk("busy_cycles", bcnt, exp);
    end
`else
    chk("latency", lat, exp);
    chk("busy_cycles", bcnt, exp);
`endif
  endtask

  task automatic check_pulse_end();
    @(negedge clk);
    chk("done_pulse_and_busy_drop", {30'd0, bus.done, bus.busy}, 32'd0);
  endtask

  initial begin
    int lat, bcnt;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'd2,        32'd14,       1'b1};
    vecs[5]  = '{OP_MULT,  32'd3,        32'd5,        32'd0,        32'd15,       1'b0};
    vecs[6]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vecs[11] = '{OP_DIVU,  32'd5,        32'd9,        32'd5,        32'd0,        1'b0};
    vecs[12] = '{OP_MULT,  32'd0,        32'd12345,    32'd0,        32'd0,        1'b0};
    vecs[13] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vecs[14] = '{OP_MULT,  32'd5,        32'd1,        32'd0,        32'd5,        1'b0};

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_div_zero", {31'd0, bus.div_zero}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);

    for (int i = 0; i < 15; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(0, lat, bcnt);
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, bus.hi, bus.lo, bus.div_zero, lat);
      chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
      chk($sformatf("vec%0d_div_zero", i), {31'd0, bus.div_zero}, {31'd0, vecs[i].dz});
      check_lat(vecs[i].op, lat, bcnt, vecs[i].dz);
      check_pulse_end();
    end

    // Stray start mid-CALC must not disturb the running divide.
    launch(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(5, lat, bcnt);
    $display("seq glitch: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
    chk("glitch_hi", bus.hi, 32'h00000000);
    chk("glitch_lo", bus.lo, 32'h80000000);
    chk("glitch_latency", lat, W + 2);
    check_pulse_end();

    // Start raised in the DONE cycle is ignored, then accepted on the first IDLE cycle.
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_done(0, lat, bcnt);
    chk("pre_done_lo", bus.lo, 32'd14);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(negedge clk);
    chk("start_in_done_ignored", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(0, lat, bcnt);
    $display("seq done-start: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
    chk("idle_accept_hi", bus.hi, 32'd0);
    chk("idle_accept_lo", bus.lo, 32'd15);
    check_lat(OP_MULT, lat, bcnt, 1'b0);
    check_pulse_end();

    // Asynchronous reset mid-CALC clears every output at once.
    launch(OP_MULTU, 32'd2, 32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    chk("busy_before_reset", {31'd0, bus.busy}, 32'd1);
    reset = 1'b0;
    #1;
    $display("seq reset: busy=%0b done=%0b dz=%0b hi=%h lo=%h",
             bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_div_zero", {31'd0, bus.div_zero}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    launch(OP_MULT, 32'd3, 32'd5);
    wait_done(0, lat, bcnt);
    $display("seq post-reset: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
    chk("post_reset_lo", bus.lo, 32'd15);
    chk("post_reset_hi", bus.hi, 32'd0);
    check_lat(OP_MULT, lat, bcnt, 1'b0);
    check_pulse_end();

`ifdef MULDIV_EARLY_TERM_EN
    // One real iteration, then the zero-multiplier shortcut: CALC, CALC, FIX, DONE.
    launch(OP_MULT, 32'd5, 32'd1);
    wait_done(0, lat, bcnt);
    $display("seq early: hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
    chk("early_lo", bus.lo, 32'd5);
    chk("early_latency", lat, 4);
    check_pulse_end();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
